// File: rtl/mem_loader.sv
`timescale 1ns/1ps
// Host-side loader for the miniRISC data memory: packs 16-bit half-words
// (low half first) into 32-bit words and writes them to consecutive addresses.
module mem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [HALF_W-1:0] in_half,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {IDLE, LO, HI, WR, FIN} state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W:0]     remaining;
  logic [HALF_W-1:0]   lo;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W:0]     loaded_q;
  logic                hs;
  logic                launch;

  // Every output decodes from the state register only, so in_ready never
  // depends combinationally on in_valid.
  assign in_ready     = (state == LO) || (state == HI);
  assign mem_we       = (state == WR);
  assign cpu_hold     = (state != IDLE);
  assign busy         = (state != IDLE);
  assign done         = (state == FIN);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = loaded_q;

  assign hs     = in_valid && in_ready;
  assign launch = (state == IDLE) && start && !abort;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (launch) state_nx = (word_count == '0) ? FIN : LO;
      LO:   if (abort) state_nx = IDLE; else if (hs) state_nx = HI;
      HI:   if (abort) state_nx = IDLE; else if (hs) state_nx = WR;
      WR:   if (abort) state_nx = IDLE; else state_nx = (remaining == ONE) ? FIN : LO;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      lo        <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      loaded_q  <= '0;
    end else begin
      if (launch) begin
        cur_addr  <= base_addr;
        remaining <= word_count;
        loaded_q  <= '0;
      end
      if (state == LO && hs) lo <= in_half;
      // The write port is loaded on the high-half handshake and then holds
      // its value until the next word, so the address stays stable in WR.
      if (state == HI && hs) begin
        addr_q  <= cur_addr;
        wdata_q <= {in_half, lo};
      end
      if (state == WR) begin
        cur_addr  <= cur_addr + 1'b1;
        remaining <= remaining - ONE;
        loaded_q  <= loaded_q + ONE;
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_loader: expected writes are queued as stimulus is
// issued and a negedge monitor pops them whenever mem_we is seen.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic [15:0] in_half;
  logic        in_ready, mem_we, cpu_hold, busy, done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] words_loaded;

  mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_half(in_half), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  we_cnt = 0;
  int  done_cnt = 0;
  bit  gap_chk = 0;
  bit  have_prev = 0;
  int  prev_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && done) done_cnt++;
    if (rst && mem_we) begin
      wr_t e;
      we_cnt++;
      check("hold_during_we", cpu_hold, 1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_we: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", mem_addr, e.addr);
        check("we_data", mem_wdata, e.data);
      end
      if (gap_chk && have_prev) check("we_gap", cyc - prev_cyc, 3);
      have_prev = 1;
      prev_cyc  = cyc;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [9:0] b, input logic [10:0] c);
    base_addr = b; word_count = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push(input logic [9:0] a, input logic [15:0] hi, input logic [15:0] lo);
    exp_q.push_back('{addr: a, data: {hi, lo}});
  endtask

  // Called just after an edge; returns just after the edge that took the half.
  task automatic send_half(input logic [15:0] h, input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_half  = h;
    while (!in_ready && t < 50) begin step(); t++; end
    if (t >= 50) check("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic finish_session(input string name, input logic [10:0] n, input int d0);
    int t = 0;
    while (!done && t < 200) begin step(); t++; end
    check({name, "_done_seen"}, done, 1);
    check({name, "_loaded"}, words_loaded, n);
    step();
    check({name, "_idle_hold"}, {busy, cpu_hold, done}, 0);
    check({name, "_done_once"}, done_cnt, d0 + 1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, {busy, cpu_hold, in_ready, mem_we, done}, 0);
    check({name, "_loaded"}, words_loaded, 0);
    check({name, "_port"}, {mem_addr, mem_wdata}, 0);
  endtask

  initial begin
    int d0, w0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base_addr = '0; word_count = '0; in_half = '0;
    repeat (3) step();
    check_zero("por");
    rst = 1'b1;
    step();

    // Reset mid-HI discards the captured low half and issues no write.
    w0 = we_cnt;
    do_start(10'd5, 11'd2);
    send_half(16'h1111, 0);
    check("mid_hi_ready", {busy, in_ready}, 2'b11);
    rst = 1'b0;
    #1;
    check_zero("rst_mid_hi");
    step();
    rst = 1'b1;
    step();
    check("rst_no_we", we_cnt, w0);

    // base 0, count 3, back-to-back halves: one write every three cycles.
    d0 = done_cnt;
    gap_chk = 1; have_prev = 0;
    push(10'd0, 16'h0000, 16'h0001);
    push(10'd1, 16'h0000, 16'h0002);
    push(10'd2, 16'h0000, 16'h0003);
    do_start(10'd0, 11'd3);
    check("b2b_hold_lo", {cpu_hold, busy, in_ready}, 3'b111);
    send_half(16'h0001, 0); send_half(16'h0000, 0);
    send_half(16'h0002, 0); send_half(16'h0000, 0);
    send_half(16'h0003, 0); send_half(16'h0000, 0);
    finish_session("b2b", 11'd3, d0);
    gap_chk = 0;

    // base 1022, count 4 with random host gaps: wraps 1023 -> 0.
    d0 = done_cnt;
    for (int i = 0; i < 4; i++)
      push(10'((1022 + i) % 1024), 16'hA000 + 16'(i), 16'h5000 + 16'(i));
    do_start(10'd1022, 11'd4);
    for (int i = 0; i < 4; i++) begin
      send_half(16'h5000 + 16'(i), $urandom_range(0, 3));
      send_half(16'hA000 + 16'(i), $urandom_range(0, 3));
    end
    finish_session("wrap", 11'd4, d0);

    // count 0 goes straight to FIN with no writes and clears words_loaded.
    d0 = done_cnt; w0 = we_cnt;
    do_start(10'd77, 11'd0);
    check("cnt0_done", {done, cpu_hold}, 2'b11);
    step();
    check("cnt0_idle", {busy, done}, 0);
    check("cnt0_loaded", words_loaded, 0);
    check("cnt0_no_we", we_cnt, w0);
    check("cnt0_done_once", done_cnt, d0 + 1);

    // Abort after two words and a low half: no done, words_loaded keeps 2.
    d0 = done_cnt; w0 = we_cnt;
    push(10'd10, 16'hB002, 16'hB001);
    push(10'd11, 16'hB004, 16'hB003);
    do_start(10'd10, 11'd5);
    send_half(16'hB001, 0); send_half(16'hB002, 1);
    send_half(16'hB003, 0); send_half(16'hB004, 2);
    send_half(16'hB005, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", {busy, cpu_hold, in_ready}, 0);
    repeat (3) step();
    check("abort_loaded", words_loaded, 2);
    check("abort_writes", we_cnt, w0 + 2);
    check("abort_no_done", done_cnt, d0);

    d0 = done_cnt;
    push(10'd20, 16'hC0DE, 16'hBEEF);
    do_start(10'd20, 11'd1);
    send_half(16'hBEEF, 0); send_half(16'hC0DE, 0);
    finish_session("post_abort", 11'd1, d0);

    // abort wins over start in IDLE.
    base_addr = 10'd30; word_count = 11'd2; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", {busy, in_ready}, 0);

    // start during LO is ignored; the original base and count are used.
    d0 = done_cnt;
    push(10'd100, 16'h2222, 16'h1111);
    push(10'd101, 16'h4444, 16'h3333);
    do_start(10'd100, 11'd2);
    base_addr = 10'd200; word_count = 11'd7; start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    send_half(16'h1111, 0); send_half(16'h2222, 0);
    send_half(16'h3333, 0); send_half(16'h4444, 0);
    finish_session("restart", 11'd2, d0);

    // Full 1024-word session from base 512 wraps through 0.
    d0 = done_cnt;
    for (int i = 0; i < 1024; i++)
      push(10'((512 + i) % 1024), ~16'(i), 16'(i));
    do_start(10'd512, 11'd1024);
    for (int i = 0; i < 1024; i++) begin
      send_half(16'(i), 0);
      send_half(~16'(i), 0);
    end
    finish_session("full", 11'd1024, d0);

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
